// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Shares one single-port SRAM between the instruction-fetch port (IF) and the
// data-memory port (DM) of the RV32I pipeline.
//
// Handshake: a requester raises *_req with address (and, for DM, we/wdata)
// and holds them until *_gnt is seen in the same cycle; the transfer happens
// on the rising edge that ends a cycle with *_gnt=1. Requests may change before
// the grant and are simply re-evaluated. A granted read returns *_rvalid with
// *_rdata exactly one cycle later; writes return nothing. A missing grant is
// a stall for the requester.
//
// Arbitration: DM has fixed priority. While IF waits, at most MAX_DM_RUN
// consecutive DM grants are given before one IF grant is forced.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   if_req/if_addr      fetch read request, if_gnt (comb), if_rvalid/if_rdata
//   dm_req/dm_we/...    data request, dm_gnt (comb), dm_rvalid/dm_rdata
//   mem_*               SRAM side; mem_rdata valid one cycle after mem_addr
//   conflict_cnt        saturating count of cycles with both requests active
//   dbg_rd_owner        current read-owner state (0 none, 1 IF, 2 DM)
//   dbg_run_cnt         current consecutive-DM-grant run length
//   dbg_cnt_load/value  debug preload of conflict_cnt (load wins over count)

module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MAX_DM_RUN = 4,
  localparam int RUN_W     = $clog2(MAX_DM_RUN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       conflict_cnt,
  output logic [1:0]        dbg_rd_owner,
  output logic [RUN_W-1:0]  dbg_run_cnt,
  input  logic              dbg_cnt_load,
  input  logic [31:0]       dbg_cnt_value
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

  owner_e           rd_owner, rd_owner_nxt;
  logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
  logic [31:0]      conflict_q;
  logic             both_req;

  assign both_req = if_req & dm_req;

  // Grant: DM wins unless IF has already waited through a full DM run.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (dm_req && !(if_req && (run_cnt == RUN_MAX))) begin
      dm_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end
  end

  // SRAM drive; everything is zero when nobody owns the cycle.
  always_comb begin
    mem_addr  = '0;
    mem_w_en  = 1'b0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_w_en  = dm_we;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Run length only counts DM grants that actually made IF wait.
  always_comb begin
    run_cnt_nxt = run_cnt;
    if (if_gnt || !if_req) begin
      run_cnt_nxt = '0;
    end else if (dm_gnt && (run_cnt != RUN_MAX)) begin
      run_cnt_nxt = run_cnt + 1'b1;
    end
  end

  // Read-owner FSM: remembers who the data coming back next cycle belongs to.
  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (if_gnt) begin
      rd_owner_nxt = OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      rd_owner_nxt = OWN_DM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner <= OWN_NONE;
      run_cnt  <= '0;
    end else begin
      rd_owner <= rd_owner_nxt;
      run_cnt  <= run_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
    end else if (dbg_cnt_load) begin
      conflict_q <= dbg_cnt_value;
    end else if (both_req && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  // Read return steering; an rdata bus is zero whenever it is not valid.
  always_comb begin
    if_rvalid = (rd_owner == OWN_IF);
    dm_rvalid = (rd_owner == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
  end

  assign conflict_cnt = conflict_q;
  assign dbg_rd_owner = rd_owner;
  assign dbg_run_cnt  = run_cnt;

endmodule
